// File: rtl/act_dot_acc.sv
// rtl/act_dot_acc.sv - 16-lane int8 dot product of activation beats against a weight FIFO, accumulated per group
// Optional ACT_DOT_ACC_SAT_EN: the accumulator saturates instead of wrapping at ACC_W bits.
module act_dot_acc #(
  parameter int LANES       = 16,
  parameter int DW          = 8,
  parameter int ACC_W       = 24,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            cfg_words,
  input  logic                  cfg_vld,
  input  logic [LANES*DW-1:0]   in_act,
  input  logic                  in_act_vld,
  input  logic                  in_finish_row,
  input  logic [LANES*DW-1:0]   wgt_data,
  input  logic                  wgt_vld,
  output logic                  wgt_rdy,
  output logic [ACC_W-1:0]      out_psum,
  output logic                  out_psum_vld,
  output logic                  out_row_done,
  output logic [2:0]            err,
  input  logic                  err_clr
);
  localparam int BW = LANES * DW;
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = $clog2(WFIFO_DEPTH);

  logic [BW-1:0]    r_fifo [WFIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [5:0]       r_cfg, r_word_cnt;
  logic [2:0]       r_err;
  logic [PW-1:0]    r_prod [LANES];
  logic             r_v1, r_first1, r_last1, r_rd1;
  logic [SW-1:0]    r_sum;
  logic             r_v2, r_first2, r_last2, r_rd2;
  logic [ACC_W-1:0] r_acc, r_out_psum;
  logic             r_out_vld, r_out_rd;

  logic             w_empty, w_push, w_pop;
  logic [BW-1:0]    w_wgt;
  logic [5:0]       w_cfg_new, w_cfg_eff, w_cnt_eff;
  logic             w_first, w_last_nat, w_last;
  logic [2:0]       w_err_new;
  logic [PW-1:0]    w_prod [LANES];
  logic [SW-1:0]    w_sum;
  logic [ACC_W-1:0] w_sum_ext, w_acc_add, w_acc_next;

  assign w_empty = (r_count == '0);
  assign wgt_rdy = (r_count != (AW+1)'(WFIFO_DEPTH));
  assign w_push  = wgt_vld & wgt_rdy;
  assign w_pop   = in_act_vld & ~w_empty;
  assign w_wgt   = w_empty ? '0 : r_fifo[r_rd_ptr];

  // A cfg_vld in the same cycle as a beat takes effect first, so that beat opens the new group.
  assign w_cfg_new  = (cfg_words == 6'd0) ? 6'd1 : cfg_words;
  assign w_cfg_eff  = cfg_vld ? w_cfg_new : r_cfg;
  assign w_cnt_eff  = cfg_vld ? 6'd0 : r_word_cnt;
  assign w_first    = (w_cnt_eff == 6'd0);
  assign w_last_nat = (w_cnt_eff == w_cfg_eff - 6'd1);
  assign w_last     = w_last_nat | in_finish_row;

  assign w_err_new[0] = in_act_vld & w_empty;
  assign w_err_new[1] = in_act_vld & in_finish_row & ~w_last_nat;
  assign w_err_new[2] = cfg_vld & (r_word_cnt != 6'd0);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = {{DW{in_act[i*DW+DW-1]}}, in_act[i*DW +: DW]} *
                  {{DW{w_wgt[i*DW+DW-1]}}, w_wgt[i*DW +: DW]};
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{(SW-PW){r_prod[i][PW-1]}}, r_prod[i]};
    end
  end

  assign w_sum_ext = {{(ACC_W-SW){r_sum[SW-1]}}, r_sum};

`ifdef ACT_DOT_ACC_SAT_EN
  logic [ACC_W:0] w_wide;
  assign w_wide = {r_acc[ACC_W-1], r_acc} + {w_sum_ext[ACC_W-1], w_sum_ext};
  always_comb begin
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      w_acc_add = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_acc_add = w_wide[ACC_W-1:0];
    end
  end
`else
  assign w_acc_add = r_acc + w_sum_ext;
`endif

  assign w_acc_next = r_first2 ? w_sum_ext : w_acc_add;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wgt_data;
  end

  // Datapath registers only; their contents are qualified by the valid bits below.
  always_ff @(posedge clk) begin
    if (in_act_vld) begin
      for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
      r_first1 <= w_first;
      r_last1  <= w_last;
      r_rd1    <= in_finish_row;
    end
    if (r_v1) begin
      r_sum    <= w_sum;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_rd2    <= r_rd1;
    end
    if (r_v2) r_acc <= w_acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cfg      <= 6'd1;
      r_word_cnt <= 6'd0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_out_psum <= '0;
      r_out_vld  <= 1'b0;
      r_out_rd   <= 1'b0;
      r_err      <= 3'b000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (cfg_vld) r_cfg <= w_cfg_new;
      // Aborting via cfg_vld only zeroes the count; the next beat is tagged first and overwrites the accumulator.
      if (in_act_vld)   r_word_cnt <= w_last ? 6'd0 : w_cnt_eff + 6'd1;
      else if (cfg_vld) r_word_cnt <= 6'd0;
      r_v1      <= in_act_vld;
      r_v2      <= r_v1;
      r_out_vld <= r_v2 & r_last2;
      r_out_rd  <= r_v2 & r_last2 & r_rd2;
      if (r_v2 & r_last2) r_out_psum <= w_acc_next;
      r_err <= w_err_new | (err_clr ? 3'b000 : r_err);
    end
  end

  assign out_psum     = r_out_psum;
  assign out_psum_vld = r_out_vld;
  assign out_row_done = r_out_rd;
  assign err          = r_err;

endmodule
